// File: rtl/act_output_packer.sv
// act_output_packer: packs 8-lane activation beats into words and buffers them in a first-word-fall-through FIFO
module act_output_packer #(
  parameter int FEATURE_WIDTH      = 16,
  parameter int PACK_BEATS         = 2,
  parameter int FIFO_DEPTH         = 16,
  parameter int ALMOST_FULL_MARGIN = 4
) (
  input  logic                                 system_clk,
  input  logic                                 rst,
  input  logic [FEATURE_WIDTH*8-1:0]           act_data,
  input  logic                                 act_data_valid,
  input  logic                                 tile_last,
  output logic [FEATURE_WIDTH*8*PACK_BEATS-1:0] wr_data,
  output logic                                 wr_last,
  output logic                                 wr_valid,
  input  logic                                 wr_ready,
  output logic                                 fifo_almost_full,
  output logic                                 overflow,
  output logic [15:0]                          word_count
);
  localparam int BEAT_W = FEATURE_WIDTH * 8;
  localparam int WORD_W = BEAT_W * PACK_BEATS;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BI = PACK_BEATS > 1 ? $clog2(PACK_BEATS) : 1;
  localparam logic [BI-1:0] LAST_B = BI'(PACK_BEATS - 1);
  localparam logic [AW:0] DEPTH_V = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] MARGIN_V = (AW+1)'(ALMOST_FULL_MARGIN);
  logic [BI-1:0] b;
  logic [PACK_BEATS-1:0][BEAT_W-1:0] slots, cur, word_q;
  logic last_q, push_q, done, pop, full, accept;
  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic mem_last [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] occ;
  assign done = act_data_valid && (b == LAST_B || tile_last);
  assign pop = wr_valid && wr_ready;
  assign full = occ == DEPTH_V;
  assign accept = push_q && (!full || pop);
  assign wr_valid = occ != '0;
  assign wr_data = wr_valid ? mem[rp] : '0;
  assign wr_last = wr_valid && mem_last[rp];
  assign fifo_almost_full = (DEPTH_V - occ) <= MARGIN_V;
  // slots above b are always zero, so a tile_last word is zero-padded for free
  always_comb begin
    cur = slots;
    cur[b] = act_data;
  end
  always_ff @(posedge system_clk) begin
    if (rst) begin
      b <= '0;
      slots <= '0;
      word_q <= '0;
      last_q <= 1'b0;
      push_q <= 1'b0;
    end else begin
      push_q <= done;
      if (done) begin
        word_q <= cur;
        last_q <= tile_last;
        slots <= '0;
        b <= '0;
      end else if (act_data_valid) begin
        slots <= cur;
        b <= b + 1'b1;
      end
    end
  end
  always_ff @(posedge system_clk) begin
    if (!rst && accept) begin
      mem[wp] <= word_q;
      mem_last[wp] <= last_q;
    end
  end
  always_ff @(posedge system_clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      occ <= '0;
      overflow <= 1'b0;
      word_count <= '0;
    end else begin
      if (accept) begin
        wp <= wp + 1'b1;
        word_count <= word_count + 16'd1;
      end
      if (pop) rp <= rp + 1'b1;
      if (push_q && !accept) overflow <= 1'b1;
      occ <= occ + (AW+1)'(accept) - (AW+1)'(pop);
    end
  end
endmodule

// File: tb/tb_act_output_packer.sv
// tb_act_output_packer: directed scenarios plus randomized traffic against a queue-based reference model
module tb_act_output_packer;
  localparam int FW = 16, PB = 2, DEPTH = 16, MARGIN = 4;
  localparam int BW = FW * 8, WW = BW * PB;
  logic system_clk = 1'b0, rst = 1'b1, act_data_valid = 1'b0, tile_last = 1'b0, wr_ready = 1'b0;
  logic [BW-1:0] act_data = '0;
  logic [WW-1:0] wr_data;
  logic wr_last, wr_valid, fifo_almost_full, overflow;
  logic [15:0] word_count;
  int checks = 0, errors = 0;
  act_output_packer #(.FEATURE_WIDTH(FW), .PACK_BEATS(PB), .FIFO_DEPTH(DEPTH), .ALMOST_FULL_MARGIN(MARGIN)) dut (
    .system_clk(system_clk), .rst(rst), .act_data(act_data), .act_data_valid(act_data_valid),
    .tile_last(tile_last), .wr_data(wr_data), .wr_last(wr_last), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .fifo_almost_full(fifo_almost_full), .overflow(overflow), .word_count(word_count));
  always #5 system_clk = ~system_clk;
  logic [WW-1:0] mq[$];
  bit mlq[$];
  logic [BW-1:0] mb[$];
  bit pend, pend_last, m_ovf;
  logic [WW-1:0] pend_data;
  logic [15:0] m_cnt;
  function automatic void model_step();
    logic [WW-1:0] w;
    if (rst) begin
      mq.delete(); mlq.delete(); mb.delete(); pend = 0; m_ovf = 0; m_cnt = 0;
      return;
    end
    if (mq.size() != 0 && wr_ready) begin
      void'(mq.pop_front()); void'(mlq.pop_front());
    end
    if (pend) begin
      if (mq.size() == DEPTH) m_ovf = 1;
      else begin mq.push_back(pend_data); mlq.push_back(pend_last); m_cnt++; end
    end
    pend = 0;
    if (act_data_valid) begin
      mb.push_back(act_data);
      if (mb.size() == PB || tile_last) begin
        w = '0;
        foreach (mb[k]) w[k*BW +: BW] = mb[k];
        pend = 1; pend_data = w; pend_last = tile_last;
        mb.delete();
      end
    end
  endfunction
  function automatic logic [BW-1:0] rnd_beat();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  task automatic drive(input bit v, input logic [BW-1:0] d, input bit tl, input bit rdy);
    act_data_valid = v; act_data = d; tile_last = tl; wr_ready = rdy;
    @(posedge system_clk);
    model_step();
    #1;
  endtask
  task automatic idle(input bit rdy);
    drive(1'b0, '0, 1'b0, rdy);
  endtask
  task automatic do_reset();
    rst = 1'b1; idle(0); idle(0); rst = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, rnd_beat(), 1'b1, 1'b1);
    drive(1'b1, rnd_beat(), 1'b1, 1'b1);
    rst = 1'b0;
    checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", wr_valid); end
    checks++; if (wr_last !== 1'b0) begin errors++; $display("FAIL reset_last got %0b want 0", wr_last); end
    checks++; if (wr_data !== '0) begin errors++; $display("FAIL reset_data got %h want 0", wr_data); end
    checks++; if (fifo_almost_full !== 1'b0) begin errors++; $display("FAIL reset_af got %0b want 0", fifo_almost_full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b want 0", overflow); end
    checks++; if (word_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d want 0", word_count); end
  endtask
  task automatic test_pack_basic();
    logic [BW-1:0] a, b, c, d;
    a = rnd_beat(); b = rnd_beat(); c = rnd_beat(); d = rnd_beat();
    do_reset();
    drive(1'b1, a, 1'b0, 1'b1);
    drive(1'b1, b, 1'b0, 1'b1);
    checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL t1_early_valid got %0b want 0", wr_valid); end
    drive(1'b1, c, 1'b0, 1'b1);
    checks++; if (wr_valid !== 1'b1) begin errors++; $display("FAIL t1_valid0 got %0b want 1", wr_valid); end
    checks++; if (wr_data !== {b, a}) begin errors++; $display("FAIL t1_word0 got %h want %h", wr_data, {b, a}); end
    checks++; if (wr_last !== 1'b0) begin errors++; $display("FAIL t1_last0 got %0b want 0", wr_last); end
    drive(1'b1, d, 1'b0, 1'b1);
    checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL t1_gap_valid got %0b want 0", wr_valid); end
    idle(1);
    checks++; if (wr_valid !== 1'b1 || wr_data !== {d, c}) begin errors++; $display("FAIL t1_word1 got %0b/%h want 1/%h", wr_valid, wr_data, {d, c}); end
    checks++; if (wr_last !== 1'b0) begin errors++; $display("FAIL t1_last1 got %0b want 0", wr_last); end
    idle(1);
    checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL t1_drained got %0b want 0", wr_valid); end
    checks++; if (word_count !== 16'd2) begin errors++; $display("FAIL t1_count got %0d want 2", word_count); end
  endtask
  task automatic test_tile_last();
    logic [BW-1:0] a, b, c;
    a = rnd_beat(); b = rnd_beat(); c = rnd_beat();
    drive(1'b1, a, 1'b0, 1'b0);
    drive(1'b1, b, 1'b0, 1'b0);
    drive(1'b1, c, 1'b1, 1'b0);
    idle(0);
    checks++; if (wr_valid !== 1'b1 || wr_data !== {b, a}) begin errors++; $display("FAIL t2_word0 got %0b/%h want 1/%h", wr_valid, wr_data, {b, a}); end
    checks++; if (wr_last !== 1'b0) begin errors++; $display("FAIL t2_last0 got %0b want 0", wr_last); end
    idle(1);
    checks++; if (wr_data !== {{BW{1'b0}}, c}) begin errors++; $display("FAIL t2_pad got %h want %h", wr_data, {{BW{1'b0}}, c}); end
    checks++; if (wr_last !== 1'b1) begin errors++; $display("FAIL t2_last1 got %0b want 1", wr_last); end
    idle(1);
    checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL t2_drained got %0b want 0", wr_valid); end
    checks++; if (word_count !== 16'd4) begin errors++; $display("FAIL t2_count got %0d want 4", word_count); end
  endtask
  task automatic test_overflow();
    logic [BW-1:0] bt [34];
    do_reset();
    for (int i = 0; i < 32; i++) begin
      bt[i] = rnd_beat();
      drive(1'b1, bt[i], 1'b0, 1'b0);
      checks++; if (fifo_almost_full !== ((i / 2) >= 12)) begin errors++; $display("FAIL t3_af beat %0d got %0b want %0b", i, fifo_almost_full, (i / 2) >= 12); end
    end
    idle(0);
    checks++; if (wr_valid !== 1'b1 || fifo_almost_full !== 1'b1) begin errors++; $display("FAIL t3_full got v%0b af%0b want v1 af1", wr_valid, fifo_almost_full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL t3_ovf_early got %0b want 0", overflow); end
    checks++; if (word_count !== 16'd16) begin errors++; $display("FAIL t3_count16 got %0d want 16", word_count); end
    bt[32] = rnd_beat(); bt[33] = rnd_beat();
    drive(1'b1, bt[32], 1'b0, 1'b0);
    drive(1'b1, bt[33], 1'b0, 1'b0);
    idle(0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL t3_ovf got %0b want 1", overflow); end
    checks++; if (word_count !== 16'd16) begin errors++; $display("FAIL t3_count_drop got %0d want 16", word_count); end
    checks++; if (wr_data !== {bt[1], bt[0]}) begin errors++; $display("FAIL t3_head got %h want %h", wr_data, {bt[1], bt[0]}); end
    idle(0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL t3_sticky got %0b want 1", overflow); end
  endtask
  task automatic test_full_push_pop();
    logic [BW-1:0] bt [32];
    logic [BW-1:0] x0, x1;
    do_reset();
    for (int i = 0; i < 32; i++) begin bt[i] = rnd_beat(); drive(1'b1, bt[i], 1'b0, 1'b0); end
    idle(0);
    x0 = rnd_beat(); x1 = rnd_beat();
    drive(1'b1, x0, 1'b0, 1'b0);
    drive(1'b1, x1, 1'b0, 1'b0);
    idle(1);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL t4_ovf got %0b want 0", overflow); end
    checks++; if (fifo_almost_full !== 1'b1) begin errors++; $display("FAIL t4_af got %0b want 1", fifo_almost_full); end
    checks++; if (word_count !== 16'd17) begin errors++; $display("FAIL t4_count got %0d want 17", word_count); end
    for (int j = 1; j < 16; j++) begin
      checks++; if (wr_valid !== 1'b1 || wr_data !== {bt[2*j+1], bt[2*j]}) begin errors++; $display("FAIL t4_drain word %0d got %0b/%h want 1/%h", j, wr_valid, wr_data, {bt[2*j+1], bt[2*j]}); end
      idle(1);
    end
    checks++; if (wr_valid !== 1'b1 || wr_data !== {x1, x0}) begin errors++; $display("FAIL t4_tail got %0b/%h want 1/%h", wr_valid, wr_data, {x1, x0}); end
    idle(1);
    checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL t4_empty got %0b want 0", wr_valid); end
  endtask
  task automatic test_mid_reset();
    logic [BW-1:0] x, y;
    do_reset();
    for (int i = 0; i < 6; i++) drive(1'b1, rnd_beat(), 1'b0, 1'b0);
    idle(0);
    drive(1'b1, rnd_beat(), 1'b0, 1'b0);
    rst = 1'b1;
    drive(1'b1, rnd_beat(), 1'b1, 1'b1);
    rst = 1'b0;
    checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL t5_valid got %0b want 0", wr_valid); end
    checks++; if (word_count !== 16'd0) begin errors++; $display("FAIL t5_count got %0d want 0", word_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL t5_ovf got %0b want 0", overflow); end
    x = rnd_beat(); y = rnd_beat();
    drive(1'b1, x, 1'b0, 1'b0);
    drive(1'b1, y, 1'b0, 1'b0);
    idle(0);
    checks++; if (wr_valid !== 1'b1 || wr_data !== {y, x}) begin errors++; $display("FAIL t5_word got %0b/%h want 1/%h", wr_valid, wr_data, {y, x}); end
    checks++; if (word_count !== 16'd1) begin errors++; $display("FAIL t5_count1 got %0d want 1", word_count); end
    idle(1);
    checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL t5_single got %0b want 0", wr_valid); end
  endtask
  task automatic test_random();
    int n = 0, cyc = 0;
    bit v, af_m;
    do_reset();
    while (n < 1000 && cyc < 20000) begin
      af_m = (DEPTH - mq.size()) <= MARGIN;
      v = !af_m && ($urandom % 3 != 0);
      drive(v, rnd_beat(), $urandom % 5 == 0, $urandom % 2 == 1);
      if (v) n++;
      cyc++;
      checks++; if (wr_valid !== (mq.size() != 0)) begin errors++; $display("FAIL t6_valid cyc %0d got %0b want %0b", cyc, wr_valid, mq.size() != 0); end
      if (mq.size() != 0) begin
        checks++; if (wr_data !== mq[0] || wr_last !== mlq[0]) begin errors++; $display("FAIL t6_head cyc %0d got %h/%0b want %h/%0b", cyc, wr_data, wr_last, mq[0], mlq[0]); end
      end
      checks++; if (fifo_almost_full !== ((DEPTH - mq.size()) <= MARGIN)) begin errors++; $display("FAIL t6_af cyc %0d got %0b", cyc, fifo_almost_full); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL t6_ovf cyc %0d got %0b want 0", cyc, overflow); end
      checks++; if (word_count !== m_cnt) begin errors++; $display("FAIL t6_count cyc %0d got %0d want %0d", cyc, word_count, m_cnt); end
    end
    checks++; if (n != 1000) begin errors++; $display("FAIL t6_budget got %0d beats want 1000", n); end
  endtask
  initial begin
    test_reset();
    test_pack_basic();
    test_tile_last();
    test_overflow();
    test_full_push_pop();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
